qam_demodulation: RTL and testbench
===================================

// Module: qam_demodulation
// PURPOSE
//  Receive-side counterpart of the QAM-4 modulator. Accepts one signed I/Q sample pair per
//  Avalon-ST beat and makes a hard-decision slice to a 2-bit Gray symbol (inverse mapping).
//  Packs PIPELINE_DEEPTH symbols into one output word, slot 0 in the LSBs, matching the
//  modulator's input word layout. Sits between the channel/ADC path and the bit sink.
// PARAMETERS
//  QAM_STAGE        4   constellation size; only 4 supported, any other value is an elaboration error
//  MOD_OUT_WIDTH    8   bits per I and per Q component (two's complement)
//  PIPELINE_DEEPTH  16  symbols per output word; must be >= 2
// PORTS
//  clock_clk              in   1                      single clock
//  reset_reset            in   1                      async, active-high reset
//  asi_in0_data           in   2*MOD_OUT_WIDTH        {I[W-1:0], Q[W-1:0]}; I in upper half
//  asi_in0_valid          in   1                      sink valid
//  asi_in0_ready          out  1                      sink ready
//  asi_in0_startofpacket  in   1                      first sample of packet
//  asi_in0_endofpacket    in   1                      last sample of packet
//  aso_out0_data          out  2*PIPELINE_DEEPTH      packed symbols; slot i at [2i+1:2i]
//  aso_out0_valid         out  1                      source valid
//  aso_out0_ready         in   1                      source ready
//  aso_out0_startofpacket out  1                      first word of packet
//  aso_out0_endofpacket   out  1                      last word of packet
//  aso_out0_empty         out  $clog2(PIPELINE_DEEPTH) unused symbol slots in this word
// BEHAVIOUR
//  - Slicer: sym = {Q[W-1], I[W-1]}. I>=0,Q>=0 -> 00; I<0,Q>=0 -> 01; I<0,Q<0 -> 11;
//    I>=0,Q<0 -> 10. Zero counts as positive. No magnitude check.
//  - Accept a beat when asi_in0_valid && asi_in0_ready.
//    asi_in0_ready = ~reset_reset & (~aso_out0_valid | aso_out0_ready). This is a
//    combinational ready->ready path.
//  - State: acc[2*DEPTH-1:0], slot counter cnt (0..DEPTH-1), sop_pend flag, and one output
//    register stage.
//  - Accepted beat writes sym into acc slot cnt.
//    - If cnt==DEPTH-1 or eop: load the output register with acc|new sym; unused slots forced
//      to 0; sop = sop_pend; eop = input eop; empty = DEPTH-1-cnt (0 when not eop).
//      Then cnt<=0, acc<=0, sop_pend<=0.
//    - Otherwise cnt<=cnt+1.
//  - Input sop accepted:
//    - If cnt!=0, the partial word is discarded and the beat is placed at slot 0.
//    - sop_pend<=1, except when sop and eop arrive on the same beat: the word is emitted with
//      sop=eop=1.
//  - Beats outside a packet (no sop seen) are still packed; their words have sop=0.
//  - Output register: aso_out0_valid set on load, cleared on (valid & ready) with no new load.
//    Back-to-back load and drain in the same cycle keeps valid=1. Data and flags hold stable
//    while valid & ~ready.
//  - Latency: completing beat accepted in cycle N -> word valid in cycle N+1. Throughput is
//    1 sample/clock when the source is ready.
//  - Reset (any time, including mid-word): aso_out0_valid=0, data=0, sop=eop=0, empty=0,
//    cnt=0, acc=0, sop_pend=0; asi_in0_ready=0 while reset is high. Partial words are lost.
// STRUCTURE
//  - Shared package qam_pkg:
//    - QAM4 symbol constants 2'b00/01/11/10.
//    - amplitude localparam (2**W)/4, so modulator and demodulator share one definition.
//    - function qam4_slice(I,Q).
//  - One sub-module, qam_symbol_packer: cnt/acc/flags plus the output register stage with
//    ready/valid, parameterised by symbol width and DEPTH.
//  - The top level holds the slicer and the Avalon-ST port mapping.
// TESTING (W=8, DEPTH=16)
//  1. Full word: 16 beats cycling (I,Q) = (64,64),(-64,64),(-64,-64),(64,-64); sop on beat 0,
//     eop on beat 15 -> one word, data 32'hB4B4B4B4, sop=1, eop=1, empty=0, one cycle after beat 15.
//  2. Short packet: beats (64,-64),(-1,0),(0,-1) with sop+eop framing -> data 32'h00000026,
//     empty=13, sop=1, eop=1.
//  3. Extremes: I=8'h80, Q=8'h7F as a single sop+eop beat -> symbol 01, data 32'h1, empty=15.
//  4. Backpressure: hold aso_out0_ready=0 while a word is valid -> asi_in0_ready=0 and
//     data/flags stable for 10 cycles. Release -> transfer, and ready returns in the same cycle.
//  5. Restart: 5 beats with no eop, then sop on a (64,64) beat plus eop -> the first 5 symbols
//     never appear; output 32'h0, empty=15, sop=1.
//  6. Reset mid-word: pulse reset after 7 beats -> valid=0, ready=0 during reset. The next
//     16-beat packet yields exactly one aligned word; a scoreboard compares against the
//     modulator reference model.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared QAM-4 definitions used by both the modulator and the demodulator.
// Holds the Gray symbol constants, the constellation amplitude and the hard-decision slicer.
package qam_pkg;

    localparam logic [1:0] QAM4_SYM_PP = 2'b00;   // I>=0, Q>=0
    localparam logic [1:0] QAM4_SYM_NP = 2'b01;   // I<0,  Q>=0
    localparam logic [1:0] QAM4_SYM_NN = 2'b11;   // I<0,  Q<0
    localparam logic [1:0] QAM4_SYM_PN = 2'b10;   // I>=0, Q<0

    localparam int QAM_SYM_W     = 2;
    localparam int QAM_SAMPLE_W  = 32;
    localparam int QAM_DEFAULT_W = 8;

    function automatic int qam_amplitude(input int w);
        return (2 ** w) / 4;
    endfunction

    localparam int QAM_AMPLITUDE = qam_amplitude(QAM_DEFAULT_W);

    // Callers sign-extend their samples to QAM_SAMPLE_W; zero slices as positive.
    function automatic logic [1:0] qam4_slice(
        input logic signed [QAM_SAMPLE_W-1:0] i,
        input logic signed [QAM_SAMPLE_W-1:0] q
    );
        logic [1:0] sym;
        case ({q[QAM_SAMPLE_W-1], i[QAM_SAMPLE_W-1]})
            2'b00:   sym = QAM4_SYM_PP;
            2'b01:   sym = QAM4_SYM_NP;
            2'b11:   sym = QAM4_SYM_NN;
            2'b10:   sym = QAM4_SYM_PN;
            default: sym = QAM4_SYM_PP;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/qam_symbol_packer.sv
// Packs DEPTH symbols per word (slot 0 in the LSBs) with packet framing,
// followed by a single ready/valid output register stage.
module qam_symbol_packer
    import qam_pkg::*;
#(
    parameter int SYM_W = 2,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SYM_W-1:0]           in_sym,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sop,
    input  logic                       in_eop,
    output logic [SYM_W*DEPTH-1:0]     out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [$clog2(DEPTH)-1:0]   out_empty
);

    localparam int CNT_W  = $clog2(DEPTH);
    localparam int WORD_W = SYM_W * DEPTH;

    logic [CNT_W-1:0]  cnt_r;
    logic [WORD_W-1:0] acc_r;
    logic              sop_pend_r;
    logic [WORD_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_sop_r;
    logic              out_eop_r;
    logic [CNT_W-1:0]  out_empty_r;

    logic              accept_s;
    logic [CNT_W-1:0]  slot_s;
    logic [WORD_W-1:0] base_s;
    logic [WORD_W-1:0] word_s;
    logic              last_s;
    logic [CNT_W-1:0]  empty_s;

    assign in_ready = ~rst & (~out_valid_r | out_ready);

    // Next word contents; a sop beat discards any partial word and restarts at slot 0.
    always_comb begin
        accept_s = in_valid & in_ready;
        slot_s   = in_sop ? {CNT_W{1'b0}} : cnt_r;
        base_s   = in_sop ? {WORD_W{1'b0}} : acc_r;
        word_s   = base_s | (WORD_W'(in_sym) << (SYM_W * int'(slot_s)));
        last_s   = (slot_s == CNT_W'(DEPTH - 1)) | in_eop;
        empty_s  = in_eop ? (CNT_W'(DEPTH - 1) - slot_s) : {CNT_W{1'b0}};
    end

    // Accumulator, slot counter and pending-sop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {WORD_W{1'b0}};
            sop_pend_r <= 1'b0;
        end else if (accept_s) begin
            if (last_s) begin
                cnt_r      <= {CNT_W{1'b0}};
                acc_r      <= {WORD_W{1'b0}};
                sop_pend_r <= 1'b0;
            end else begin
                cnt_r      <= slot_s + CNT_W'(1);
                acc_r      <= word_s;
                sop_pend_r <= sop_pend_r | in_sop;
            end
        end
    end

    // Output register: load wins over drain so back-to-back words keep valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= {WORD_W{1'b0}};
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_empty_r <= {CNT_W{1'b0}};
        end else if (accept_s && last_s) begin
            out_data_r  <= word_s;
            out_valid_r <= 1'b1;
            out_sop_r   <= sop_pend_r | in_sop;
            out_eop_r   <= in_eop;
            out_empty_r <= empty_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_sop   = out_sop_r;
    assign out_eop   = out_eop_r;
    assign out_empty = out_empty_r;

endmodule

// File: rtl/qam_demodulation.sv
// QAM-4 hard-decision demodulator: slices each I/Q beat to a Gray symbol and
// packs PIPELINE_DEEPTH symbols per Avalon-ST output word.
module qam_demodulation
    import qam_pkg::*;
#(
    parameter int QAM_STAGE       = 4,
    parameter int MOD_OUT_WIDTH   = 8,
    parameter int PIPELINE_DEEPTH = 16
) (
    input  logic                               clock_clk,
    input  logic                               reset_reset,
    input  logic [2*MOD_OUT_WIDTH-1:0]         asi_in0_data,
    input  logic                               asi_in0_valid,
    output logic                               asi_in0_ready,
    input  logic                               asi_in0_startofpacket,
    input  logic                               asi_in0_endofpacket,
    output logic [2*PIPELINE_DEEPTH-1:0]       aso_out0_data,
    output logic                               aso_out0_valid,
    input  logic                               aso_out0_ready,
    output logic                               aso_out0_startofpacket,
    output logic                               aso_out0_endofpacket,
    output logic [$clog2(PIPELINE_DEEPTH)-1:0] aso_out0_empty
);

    if (QAM_STAGE != 4) begin : g_bad_stage
        $error("qam_demodulation: only QAM_STAGE=4 is supported");
    end
    if (PIPELINE_DEEPTH < 2) begin : g_bad_depth
        $error("qam_demodulation: PIPELINE_DEEPTH must be >= 2");
    end

    logic signed [MOD_OUT_WIDTH-1:0] i_s;
    logic signed [MOD_OUT_WIDTH-1:0] q_s;
    logic [QAM_SYM_W-1:0]            sym_s;

    // Split the beat (I in the upper half) and slice on the sign bits.
    always_comb begin
        i_s   = asi_in0_data[2*MOD_OUT_WIDTH-1:MOD_OUT_WIDTH];
        q_s   = asi_in0_data[MOD_OUT_WIDTH-1:0];
        sym_s = qam4_slice(QAM_SAMPLE_W'(i_s), QAM_SAMPLE_W'(q_s));
    end

    qam_symbol_packer #(
        .SYM_W (QAM_SYM_W),
        .DEPTH (PIPELINE_DEEPTH)
    ) u_packer (
        .clk       (clock_clk),
        .rst       (reset_reset),
        .in_sym    (sym_s),
        .in_valid  (asi_in0_valid),
        .in_ready  (asi_in0_ready),
        .in_sop    (asi_in0_startofpacket),
        .in_eop    (asi_in0_endofpacket),
        .out_data  (aso_out0_data),
        .out_valid (aso_out0_valid),
        .out_ready (aso_out0_ready),
        .out_sop   (aso_out0_startofpacket),
        .out_eop   (aso_out0_endofpacket),
        .out_empty (aso_out0_empty)
    );

endmodule

// File: tb/tb_qam_demodulation.sv
// Directed testbench for qam_demodulation (W=8, DEPTH=16) with hand-computed expectations
// and a modulator reference model for the post-reset packet.
module tb_qam_demodulation;
    import qam_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2*W-1:0]    in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sop = 1'b0;
    logic              in_eop = 1'b0;
    logic [2*DEPTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_sop;
    logic              out_eop;
    logic [3:0]        out_empty;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    qam_demodulation #(
        .QAM_STAGE       (4),
        .MOD_OUT_WIDTH   (W),
        .PIPELINE_DEEPTH (DEPTH)
    ) dut (
        .clock_clk              (clk),
        .reset_reset            (rst),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_ready          (in_ready),
        .asi_in0_startofpacket  (in_sop),
        .asi_in0_endofpacket    (in_eop),
        .aso_out0_data          (out_data),
        .aso_out0_valid         (out_valid),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (out_sop),
        .aso_out0_endofpacket   (out_eop),
        .aso_out0_empty         (out_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int i, input int q, input logic s, input logic e);
        int waited;
        logic [W-1:0] iv;
        logic [W-1:0] qv;
        iv = W'(i);
        qv = W'(q);
        in_data  = {iv, qv};
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("send_timeout", 32'(waited), 32'd0);
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic s,
                              input logic e, input logic [3:0] emp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  out_data, d);
        check({tag, "_sop"},   32'(out_sop), 32'(s));
        check({tag, "_eop"},   32'(out_eop), 32'(e));
        check({tag, "_empty"}, 32'(out_empty), 32'(emp));
    endtask

    // Modulator reference: Gray symbol -> (I,Q) at +/- amplitude.
    function automatic int mod_i(input logic [1:0] sym);
        return sym[0] ? -QAM_AMPLITUDE : QAM_AMPLITUDE;
    endfunction
    function automatic int mod_q(input logic [1:0] sym);
        return sym[1] ? -QAM_AMPLITUDE : QAM_AMPLITUDE;
    endfunction

    initial begin
        logic [31:0] held;
        logic [31:0] exp_word;
        logic [1:0]  sym;
        int          ii [4];
        int          qq [4];
        ii = '{64, -64, -64, 64};
        qq = '{64, 64, -64, -64};

        // Reset state
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_flags", {28'd0, out_sop, out_eop, out_empty[1:0]}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // 1. Full word
        for (int k = 0; k < DEPTH; k++) begin
            send(ii[k % 4], qq[k % 4], k == 0, k == DEPTH - 1);
            if (k == DEPTH - 2) check("t1_no_early_word", 32'(out_valid), 32'd0);
        end
        check_word("t1", 32'hB4B4B4B4, 1'b1, 1'b1, 4'd0);
        tick();
        check("t1_drained", 32'(out_valid), 32'd0);

        // 2. Short packet
        send(64, -64, 1'b1, 1'b0);
        send(-1, 0, 1'b0, 1'b0);
        send(0, -1, 1'b0, 1'b1);
        check_word("t2", 32'h00000026, 1'b1, 1'b1, 4'd13);
        tick();

        // 3. Extremes
        send(-128, 127, 1'b1, 1'b1);
        check_word("t3", 32'h00000001, 1'b1, 1'b1, 4'd15);
        tick();

        // 4. Backpressure, then back-to-back load and drain
        out_ready = 1'b0;
        send(64, 64, 1'b1, 1'b1);
        check_word("t4a", 32'h0, 1'b1, 1'b1, 4'd15);
        held     = out_data;
        in_data  = {8'hC0, 8'hC0};
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_eop   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("t4_stall_ready", 32'(in_ready), 32'd0);
            check("t4_stall_data",  out_data, held);
            check("t4_stall_valid", 32'(out_valid), 32'd1);
            tick();
        end
        check("t4_stall_empty", 32'(out_empty), 32'd15);
        out_ready = 1'b1;
        #1;
        check("t4_ready_same_cycle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        check_word("t4b", 32'h00000003, 1'b1, 1'b1, 4'd15);
        tick();
        check("t4_drained", 32'(out_valid), 32'd0);

        // 5. Restart discards a partial word
        for (int k = 0; k < 5; k++) send(-64, -64, 1'b0, 1'b0);
        check("t5_no_word", 32'(out_valid), 32'd0);
        send(64, 64, 1'b1, 1'b1);
        check_word("t5", 32'h0, 1'b1, 1'b1, 4'd15);
        tick();

        // 6. Reset mid-word, then a scoreboarded packet
        for (int k = 0; k < 7; k++) send(-64, 64, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        tick();
        check("t6_rst_ready2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        exp_word = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            sym = 2'($urandom_range(0, 3));
            exp_word[2*k +: 2] = sym;
            send(mod_i(sym), mod_q(sym), k == 0, k == DEPTH - 1);
            if (k == DEPTH - 2) check("t6_no_early_word", 32'(out_valid), 32'd0);
        end
        check_word("t6", exp_word, 1'b1, 1'b1, 4'd0);
        tick();
        check("t6_single_word", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
